sw_debounce: RTL and testbench

- Input-conditioning stage that sits directly upstream of the 3-bit full adder on the Basys3 board.
- Takes raw, bouncing, asynchronous slide-switch levels and synchronises each bit to the 100 MHz system clock.
- Debounces each bit independently and delivers clean, stable levels to the adder's sw[2:0] inputs.
- Also produces per-bit edge strobes and an any-change strobe for downstream display and logging logic.

---
 rtl/sw_debounce_pkg.sv | 13 +
 rtl/sw_debounce_if.sv | 26 ++
 rtl/debounce_bit.sv | 93 +++++++++
 rtl/sw_debounce.sv | 37 +++
 tb/tb_sw_debounce.sv | 133 +++++++++++++
 5 files changed

// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared types and settle-window constants for the switch debouncer
package sw_debounce_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        SETTLING = 1'b1
    } db_state_t;

    // 10 ms at 100 MHz on the board; a short window keeps benches fast
    localparam int DB_CYCLES_HW  = 1000000;
    localparam int DB_CYCLES_SIM = 4;

endpackage

// File: rtl/sw_debounce_if.sv
// rtl/sw_debounce_if.sv - raw switch input and conditioned level/strobe outputs
interface sw_debounce_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    modport master (
        output sw_raw,
        input  sw_db,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    modport slave (
        input  sw_raw,
        output sw_db,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );
endinterface

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one switch bit: two-flop synchroniser, settle counter, edge strobes
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DB_CYCLES_HW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    db_state_t        state;
    db_state_t        state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             db_nx;
    logic             rise_nx;
    logic             fall_nx;

    // Bring the asynchronous pin into the clock domain; only s2 is used below
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // State, counter and all outputs are registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            db    <= db_nx;
            rise  <= rise_nx;
            fall  <= fall_nx;
        end
    end

    // Accept a new level only after it has differed from db for STABLE_CYCLES samples
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        db_nx    = db;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (s2 != db) begin
                    state_nx = SETTLING;
                    cnt_nx   = CNT_W'(1);
                end
            end
            SETTLING: begin
                if (s2 == db) begin
                    // bounced back before the window closed
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    db_nx    = s2;
                    rise_nx  = s2;
                    fall_nx  = ~s2;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-bit switch debouncer feeding the 3-bit adder inputs
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int STABLE_CYCLES = DB_CYCLES_HW
) (
    input  logic           clk,
    input  logic           rst_n,
    sw_debounce_if.slave   bus
);

    logic [WIDTH-1:0] db_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    // Bits are conditioned completely independently of one another
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (bus.sw_raw[i]),
            .db    (db_w[i]),
            .rise  (rise_w[i]),
            .fall  (fall_w[i])
        );
    end

    assign bus.sw_db      = db_w;
    assign bus.sw_rise    = rise_w;
    assign bus.sw_fall    = fall_w;
    // Built only from registered strobes, so simultaneous bit updates give one pulse
    assign bus.sw_changed = |(rise_w | fall_w);

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed self-checking bench for sw_debounce
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    sw_debounce_if #(.WIDTH(3)) bus ();

    sw_debounce #(
        .WIDTH         (3),
        .STABLE_CYCLES (DB_CYCLES_SIM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // packed as {changed, fall[2:0], rise[2:0], db[2:0]}
    task automatic check_out(input string tag, input logic [2:0] db, input logic [2:0] rise,
                             input logic [2:0] fall, input logic chg);
        check(tag, {22'b0, bus.sw_changed, bus.sw_fall, bus.sw_rise, bus.sw_db},
                   {22'b0, chg, fall, rise, db});
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Called right after sw_raw changes: the next edge is edge 0, update lands on edge 5
    task automatic expect_settle(input string tag, input logic [2:0] old_v, input logic [2:0] new_v);
        for (int k = 0; k < 5; k++) begin
            step();
            check_out({tag, "_wait"}, old_v, 3'b000, 3'b000, 1'b0);
        end
        step();
        check_out({tag, "_edge"}, new_v, new_v & ~old_v, old_v & ~new_v, |(old_v ^ new_v));
        step();
        check_out({tag, "_after"}, new_v, 3'b000, 3'b000, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] code;
        logic [1:0] exp_sum;
        logic [1:0] got_sum;

        rst_n      = 1'b0;
        bus.sw_raw = 3'b111;
        repeat (3) step();
        check_out("reset_hold", 3'b000, 3'b000, 3'b000, 1'b0);

        rst_n = 1'b1;
        expect_settle("reset_release", 3'b000, 3'b111);

        bus.sw_raw = 3'b000;
        expect_settle("fall_all", 3'b111, 3'b000);

        bus.sw_raw = 3'b001;
        expect_settle("clean_step", 3'b000, 3'b001);

        for (int len = 1; len <= 3; len++) begin
            bus.sw_raw = 3'b011;
            for (int k = 0; k < len; k++) begin
                step();
                check_out("bounce_hi", 3'b001, 3'b000, 3'b000, 1'b0);
            end
            bus.sw_raw = 3'b001;
            for (int k = 0; k < len; k++) begin
                step();
                check_out("bounce_lo", 3'b001, 3'b000, 3'b000, 1'b0);
            end
        end
        repeat (6) begin
            step();
            check_out("bounce_quiet", 3'b001, 3'b000, 3'b000, 1'b0);
        end
        bus.sw_raw = 3'b011;
        expect_settle("bounce_accept", 3'b001, 3'b011);

        bus.sw_raw = 3'b100;
        expect_settle("simultaneous", 3'b011, 3'b100);

        bus.sw_raw = 3'b011;
        repeat (4) begin
            step();
            check_out("midsettle_wait", 3'b100, 3'b000, 3'b000, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        check_out("reset_async", 3'b000, 3'b000, 3'b000, 1'b0);
        repeat (2) begin
            step();
            check_out("reset_low", 3'b000, 3'b000, 3'b000, 1'b0);
        end
        rst_n = 1'b1;
        expect_settle("reset_restart", 3'b000, 3'b011);

        for (int c = 0; c < 8; c++) begin
            code       = 3'(c);
            bus.sw_raw = code;
            repeat (6) step();
            check("adder_db", {29'b0, bus.sw_db}, {29'b0, code});
            exp_sum = 2'(c[0]) + 2'(c[1]) + 2'(c[2]);
            got_sum = 2'(bus.sw_db[0]) + 2'(bus.sw_db[1]) + 2'(bus.sw_db[2]);
            check("adder_sum_carry", {30'b0, got_sum}, {30'b0, exp_sum});
            repeat (4) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
